// File: rtl/fifo_fwft_adapter.sv
// fifo_fwft_adapter: turns a registered-read FIFO port (rd_en, data one cycle
// later, empty) into a first-word-fall-through valid/ready stream. A two-entry
// buffer (output register plus skid register) absorbs the read pipeline delay.
// This sustains one beat per cycle under backpressure without losing or
// duplicating words.
module fifo_fwft_adapter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            level
);

    // State bits are {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_TWO   = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  inflight_q;
    logic [1:0]            level_q;

    logic       out_valid;
    logic       skid_valid;
    logic       pop;
    logic       capture;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;

    assign out_valid  = state_q[1];
    assign skid_valid = state_q[0];
    assign pop        = out_valid & m_ready;
    assign capture    = inflight_q;

    assign occ           = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight_q};
    assign occ_after_pop = occ - {1'b0, pop};

    // Issue a read only when the word it returns is guaranteed a free slot.
    always_comb begin
        fifo_rd_en = !rst && !fifo_empty && (occ_after_pop < 2'd2);
    end

    // Next-state and data steering: arriving word goes to the output register
    // when it is free and skid is empty, otherwise to skid; pop drains skid.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        case (state_q)
            S_EMPTY: begin
                if (capture) begin
                    out_data_d = fifo_rd_data;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (capture) begin
                    if (pop) begin
                        out_data_d = fifo_rd_data;
                    end else begin
                        skid_data_d = fifo_rd_data;
                        state_d     = S_TWO;
                    end
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    out_data_d = skid_data_q;
                    if (capture) begin
                        skid_data_d = fifo_rd_data;
                    end else begin
                        state_d = S_ONE;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // State, data and read-pipeline registers; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            inflight_q  <= 1'b0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            inflight_q  <= fifo_rd_en;
            level_q     <= {state_d == S_TWO, state_d == S_ONE};
        end
    end

    // The issue rule must keep a full buffer from receiving an unpopped word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(state_q == S_TWO && capture && !pop));
            assert (state_q != 2'b01);
        end
    end

    assign m_valid = out_valid;
    assign m_data  = out_data_q;
    assign level   = level_q;

endmodule
